sram_dp_avl: RTL and testbench

- Parametrised true-dual-port on-chip SRAM with two Avalon-MM slave ports (s1 = port A, s2 = port B) on a single clock.
- Successor to the fixed 4096x16 dual-port buffers feeding the NPU datapath.
- Adds over those buffers:
  - configurable width, depth and read latency
  - readdatavalid / waitrequest handshakes
  - a hardware clear engine (on reset and on request)
  - deterministic same-address collision resolution
- Instantiated by the Qsys wrapper as weight/activation scratch memory.

---
 rtl/sram_dp_avl_if.sv | 21 ++
 rtl/sram_dp_avl.sv | 123 ++++++++++++
 tb/tb_sram_dp_avl.sv | 189 ++++++++++++++++++
 3 files changed

// File: rtl/sram_dp_avl_if.sv
// sram_dp_avl_if: Avalon-MM slave port bundle for sram_dp_avl
// Ports: address, chipselect, read, write, byteenable, writedata (master -> slave);
// readdata, readdatavalid, waitrequest (slave -> master).
interface sram_dp_avl_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12
);
  logic [ADDR_WIDTH-1:0]   address;
  logic                    chipselect;
  logic                    read;
  logic                    write;
  logic [DATA_WIDTH/8-1:0] byteenable;
  logic [DATA_WIDTH-1:0]   writedata;
  logic [DATA_WIDTH-1:0]   readdata;
  logic                    readdatavalid;
  logic                    waitrequest;
  modport master (output address, chipselect, read, write, byteenable, writedata,
                  input readdata, readdatavalid, waitrequest);
  modport slave (input address, chipselect, read, write, byteenable, writedata,
                 output readdata, readdatavalid, waitrequest);
endinterface

// File: rtl/sram_dp_avl.sv
// sram_dp_avl: true dual-port SRAM with two Avalon-MM slave ports and a clear engine
// Ports: clk, reset_n (async active-low), clear_req (pulse), clear_busy,
// a / b (sram_dp_avl_if.slave, port A wins same-address lane collisions).
// Optional: define SRAM_DP_WRFWD_EN to forward a cross-port write to a same-cycle reader.
module sram_dp_avl #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 12,
  parameter int READ_LATENCY = 1,
  parameter int CLEAR_ON_RESET = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic clear_req,
  output logic clear_busy,
  sram_dp_avl_if.slave a,
  sram_dp_avl_if.slave b
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;
  typedef enum logic {IDLE, CLEAR} state_t;
  state_t state;
  logic [ADDR_WIDTH-1:0] cnt;
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  function automatic logic [DATA_WIDTH-1:0] lanes(input logic [NB-1:0] be);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int i = 0; i < NB; i++) m[i*8 +: 8] = {8{be[i]}};
    return m;
  endfunction
  logic a_go, b_go, a_wr, b_wr, a_rd, b_rd, same;
  logic [NB-1:0] b_be;
  logic [DATA_WIDTH-1:0] a_new, b_new, a_word, b_word;
  assign a_go = a.chipselect & (a.read | a.write) & ~clear_busy;
  assign b_go = b.chipselect & (b.read | b.write) & ~clear_busy;
  assign a_wr = a_go & a.write;
  assign b_wr = b_go & b.write;
  // a simultaneous write drops the read
  assign a_rd = a_go & a.read & ~a.write;
  assign b_rd = b_go & b.read & ~b.write;
  assign same = a.address == b.address;
  assign b_be = b.byteenable & ~({NB{a_wr & same}} & a.byteenable);
  // A's word is built on top of B's so that a same-address collision keeps B's
  // non-overlapping lanes even though A's store lands last
  assign b_new = (mem[b.address] & ~lanes(b_be)) | (b.writedata & lanes(b_be));
  assign a_new = (((b_wr & same) ? b_new : mem[a.address]) & ~lanes(a.byteenable))
               | (a.writedata & lanes(a.byteenable));
`ifdef SRAM_DP_WRFWD_EN
  assign a_word = (b_wr & same) ? b_new : mem[a.address];
  assign b_word = (a_wr & same) ? a_new : mem[b.address];
`else
  assign a_word = mem[a.address];
  assign b_word = mem[b.address];
`endif
  always_ff @(posedge clk) begin
    if (state == CLEAR) mem[cnt] <= CLEAR_VALUE;
    else begin
      if (b_wr) mem[b.address] <= b_new;
      if (a_wr) mem[a.address] <= a_new;
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= CLEAR_ON_RESET != 0 ? CLEAR : IDLE;
      clear_busy <= CLEAR_ON_RESET != 0;
      cnt <= '0;
    end else if (state == IDLE) begin
      if (clear_req) begin
        state <= CLEAR;
        clear_busy <= 1'b1;
      end
    end else begin
      cnt <= cnt + 1'b1;
      if (&cnt) begin
        state <= IDLE;
        clear_busy <= 1'b0;
      end
    end
  end
  assign a.waitrequest = clear_busy;
  assign b.waitrequest = clear_busy;
  logic a_v1, b_v1;
  logic [DATA_WIDTH-1:0] a_d1, b_d1;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_v1 <= 1'b0;
      b_v1 <= 1'b0;
      a_d1 <= '0;
      b_d1 <= '0;
    end else begin
      a_v1 <= a_rd;
      b_v1 <= b_rd;
      if (a_rd) a_d1 <= a_word;
      if (b_rd) b_d1 <= b_word;
    end
  end
  if (READ_LATENCY == 2) begin : g_lat2
    logic a_v2, b_v2;
    logic [DATA_WIDTH-1:0] a_d2, b_d2;
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        a_v2 <= 1'b0;
        b_v2 <= 1'b0;
        a_d2 <= '0;
        b_d2 <= '0;
      end else begin
        a_v2 <= a_v1;
        b_v2 <= b_v1;
        if (a_v1) a_d2 <= a_d1;
        if (b_v1) b_d2 <= b_d1;
      end
    end
    assign a.readdatavalid = a_v2;
    assign b.readdatavalid = b_v2;
    assign a.readdata = a_d2;
    assign b.readdata = b_d2;
  end else begin : g_lat1
    assign a.readdatavalid = a_v1;
    assign b.readdatavalid = b_v1;
    assign a.readdata = a_d1;
    assign b.readdata = b_d1;
  end
endmodule

// File: tb/tb_sram_dp_avl.sv
// tb_sram_dp_avl: directed self-checking bench for sram_dp_avl at read latency 1 and 2
module tb_sram_dp_avl;
`ifdef SRAM_DP_WRFWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif
  logic clk, reset_n, clear_req, busy1, busy2;
  logic [3:0] a_address, b_address;
  logic a_chipselect, a_read, a_write, b_chipselect, b_read, b_write;
  logic [1:0] a_byteenable, b_byteenable;
  logic [15:0] a_writedata, b_writedata;
  int checks = 0, errors = 0;
  sram_dp_avl_if #(.DATA_WIDTH(16), .ADDR_WIDTH(4)) a1(), b1(), a2(), b2();
  assign a1.address = a_address, a2.address = a_address;
  assign a1.chipselect = a_chipselect, a2.chipselect = a_chipselect;
  assign a1.read = a_read, a2.read = a_read;
  assign a1.write = a_write, a2.write = a_write;
  assign a1.byteenable = a_byteenable, a2.byteenable = a_byteenable;
  assign a1.writedata = a_writedata, a2.writedata = a_writedata;
  assign b1.address = b_address, b2.address = b_address;
  assign b1.chipselect = b_chipselect, b2.chipselect = b_chipselect;
  assign b1.read = b_read, b2.read = b_read;
  assign b1.write = b_write, b2.write = b_write;
  assign b1.byteenable = b_byteenable, b2.byteenable = b_byteenable;
  assign b1.writedata = b_writedata, b2.writedata = b_writedata;
  sram_dp_avl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(1), .CLEAR_ON_RESET(1),
                .CLEAR_VALUE(16'hA5A5)) dut1 (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy1), .a(a1), .b(b1));
  sram_dp_avl #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .READ_LATENCY(2), .CLEAR_ON_RESET(1),
                .CLEAR_VALUE(16'hA5A5)) dut2 (
    .clk(clk), .reset_n(reset_n), .clear_req(clear_req), .clear_busy(busy2), .a(a2), .b(b2));
  initial clk = 1'b0;
  always #5 clk = ~clk;
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not end, got running expected finished");
    $fatal(1);
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] obs(input logic v, input logic [15:0] d, input logic w);
    return w ? {15'b0, v, d} : {31'b0, v};
  endfunction
  function automatic logic [31:0] exv(input logic w, input logic [15:0] d);
    return w ? {15'b0, 1'b1, d} : 32'b0;
  endfunction
  task automatic idle();
    a_chipselect = 0; a_read = 0; a_write = 0;
    b_chipselect = 0; b_read = 0; b_write = 0;
  endtask
  task automatic step(input logic ar, input logic aw, input logic [3:0] aad,
                      input logic [15:0] ad, input logic [1:0] abe,
                      input logic br, input logic bw, input logic [3:0] bad,
                      input logic [15:0] bd, input logic [1:0] bbe);
    a_chipselect = ar | aw; a_read = ar; a_write = aw;
    a_address = aad; a_writedata = ad; a_byteenable = abe;
    b_chipselect = br | bw; b_read = br; b_write = bw;
    b_address = bad; b_writedata = bd; b_byteenable = bbe;
    @(negedge clk);
    idle();
  endtask
  task automatic rd_chk(input string tag, input logic av, input logic [15:0] ad,
                        input logic bv, input logic [15:0] bd);
    chk({tag, " a lat1"}, obs(a1.readdatavalid, a1.readdata, av), exv(av, ad));
    chk({tag, " b lat1"}, obs(b1.readdatavalid, b1.readdata, bv), exv(bv, bd));
    chk({tag, " lat2 early"}, {30'b0, a2.readdatavalid, b2.readdatavalid}, 32'b0);
    @(negedge clk);
    chk({tag, " a lat2"}, obs(a2.readdatavalid, a2.readdata, av), exv(av, ad));
    chk({tag, " b lat2"}, obs(b2.readdatavalid, b2.readdata, bv), exv(bv, bd));
    chk({tag, " lat1 late"}, {30'b0, a1.readdatavalid, b1.readdatavalid}, 32'b0);
  endtask
  task automatic count_busy(input int pulse_at, output int n1, output int n2, output logic stale);
    int n;
    n = 0; n1 = 0; n2 = 0; stale = 0;
    while ((busy1 || busy2) && n < 100) begin
      n1 += int'(busy1); n2 += int'(busy2);
      stale |= a1.readdatavalid | b1.readdatavalid | a2.readdatavalid | b2.readdatavalid;
      clear_req = (n == pulse_at);
      n++;
      @(negedge clk);
    end
    clear_req = 0;
  endtask
  int n1, n2;
  logic stale;
  initial begin
    reset_n = 0; clear_req = 0;
    a_address = 0; a_writedata = 0; a_byteenable = 0;
    b_address = 0; b_writedata = 0; b_byteenable = 0;
    idle();
    repeat (2) @(negedge clk);
    chk("reset busy/wait", {26'b0, busy1, busy2, a1.waitrequest, b1.waitrequest,
        a2.waitrequest, b2.waitrequest}, 32'h3F);
    chk("reset valid", {28'b0, a1.readdatavalid, b1.readdatavalid, a2.readdatavalid,
        b2.readdatavalid}, 32'b0);
    chk("reset data lat1", {a1.readdata, b1.readdata}, 32'b0);
    chk("reset data lat2", {a2.readdata, b2.readdata}, 32'b0);
    reset_n = 1;
    count_busy(-1, n1, n2, stale);
    chk("reset clear len lat1", n1, 16);
    chk("reset clear len lat2", n2, 16);
    chk("idle wait", {28'b0, a1.waitrequest, b1.waitrequest, a2.waitrequest,
        b2.waitrequest}, 32'b0);
    for (int i = 0; i < 16; i++) begin
      step(1, 0, 4'(i), 0, 0, 0, 0, 0, 0, 0);
      rd_chk("clear rd", 1, 16'hA5A5, 0, 0);
    end
    step(0, 1, 5, 16'h1234, 2'b11, 0, 0, 0, 0, 0);
    step(0, 1, 5, 16'hFF00, 2'b10, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
    rd_chk("byte lanes", 0, 0, 1, 16'hFF34);
    step(0, 1, 5, 16'h0000, 2'b00, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 5, 0, 0);
    rd_chk("be zero", 0, 0, 1, 16'hFF34);
    step(0, 1, 7, 16'h1111, 2'b01, 0, 1, 7, 16'h2222, 2'b11);
    step(1, 0, 7, 0, 0, 0, 0, 0, 0, 0);
    rd_chk("coll partial", 1, 16'h2211, 0, 0);
    step(0, 1, 7, 16'h1111, 2'b11, 0, 1, 7, 16'h2222, 2'b11);
    step(0, 0, 0, 0, 0, 1, 0, 7, 0, 0);
    rd_chk("coll full", 0, 0, 1, 16'h1111);
    step(1, 1, 9, 16'h5A5A, 2'b11, 0, 0, 0, 0, 0);
    rd_chk("rd+wr no valid", 0, 0, 0, 0);
    step(1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    rd_chk("rd+wr data", 1, 16'h5A5A, 0, 0);
    step(0, 1, 9, 16'h1357, 2'b11, 0, 0, 0, 0, 0);
    step(1, 0, 9, 0, 0, 0, 0, 0, 0, 0);
    rd_chk("wr then rd", 1, 16'h1357, 0, 0);
    step(0, 1, 3, 16'h0000, 2'b11, 0, 0, 0, 0, 0);
    step(0, 1, 3, 16'hBEEF, 2'b11, 1, 0, 3, 0, 0);
    rd_chk("rdw b reads", 0, 0, 1, FWD ? 16'hBEEF : 16'h0000);
    step(0, 0, 0, 0, 0, 1, 0, 3, 0, 0);
    rd_chk("rdw b after", 0, 0, 1, 16'hBEEF);
    step(1, 0, 3, 0, 0, 0, 1, 3, 16'hCAFE, 2'b01);
    rd_chk("rdw a reads", 1, FWD ? 16'hBEFE : 16'hBEEF, 0, 0);
    step(1, 0, 3, 0, 0, 0, 0, 0, 0, 0);
    rd_chk("rdw a after", 1, 16'hBEFE, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 1, 4'(i), 16'(16'h1000 + i), 2'b11, 0, 0, 0, 0, 0);
    b_chipselect = 1; b_read = 1; b_address = 0;
    @(negedge clk);
    chk("stream 0 lat1", obs(b1.readdatavalid, b1.readdata, 1), exv(1, 16'h1000));
    b_address = 1;
    @(negedge clk);
    chk("stream 1 lat1", obs(b1.readdatavalid, b1.readdata, 1), exv(1, 16'h1001));
    chk("stream 0 lat2", obs(b2.readdatavalid, b2.readdata, 1), exv(1, 16'h1000));
    b_address = 2; clear_req = 1;
    @(negedge clk);
    chk("stream 2 lat1", obs(b1.readdatavalid, b1.readdata, 1), exv(1, 16'h1002));
    chk("stream 1 lat2", obs(b2.readdatavalid, b2.readdata, 1), exv(1, 16'h1001));
    chk("clear req busy", {28'b0, busy1, busy2, b1.waitrequest, b2.waitrequest}, 32'hF);
    b_address = 3; clear_req = 0;
    @(negedge clk);
    chk("stalled rd lat1", obs(b1.readdatavalid, b1.readdata, 0), 32'b0);
    chk("stream 2 lat2", obs(b2.readdatavalid, b2.readdata, 1), exv(1, 16'h1002));
    @(negedge clk);
    count_busy(6, n1, n2, stale);
    idle();
    chk("req clear len lat1", n1 + 2, 16);
    chk("req clear len lat2", n2 + 2, 16);
    chk("no valid in clear", {31'b0, stale}, 32'b0);
    step(1, 0, 2, 0, 0, 0, 0, 0, 0, 0);
    rd_chk("after req clear", 1, 16'hA5A5, 0, 0);
    clear_req = 1;
    step(0, 0, 0, 0, 0, 1, 0, 0, 0, 0);
    clear_req = 0;
    chk("pend rd lat1", obs(b1.readdatavalid, b1.readdata, 1), exv(1, 16'hA5A5));
    reset_n = 0;
    #1;
    chk("reset abort valid", {28'b0, a1.readdatavalid, b1.readdatavalid, a2.readdatavalid,
        b2.readdatavalid}, 32'b0);
    @(negedge clk);
    chk("reset abort busy", {30'b0, busy1, busy2}, 32'h3);
    chk("reset abort lat2", {31'b0, b2.readdatavalid}, 32'b0);
    reset_n = 1;
    count_busy(-1, n1, n2, stale);
    chk("restart len lat1", n1, 16);
    chk("restart len lat2", n2, 16);
    chk("no stale valid", {31'b0, stale}, 32'b0);
    step(0, 0, 0, 0, 0, 1, 0, 15, 0, 0);
    rd_chk("after restart", 0, 0, 1, 16'hA5A5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
